shift_normalizer: RTL and testbench
===================================

Name: shift_normalizer

Overview:
- Multi-cycle normalizer; works in the reverse direction of the datapath barrel shifter.
- Input: a 16-bit value. Output: the shift count that normalizes it, plus the normalized value.
  - Left mode: count leading zeros, shift left until bit 15 = 1.
  - Right mode: count trailing zeros, shift right logically until bit 0 = 1.
- Binary search over the 8/4/2/1 stages, one stage per clock, largest stage first.
- Feeds Cnt back to the shift/ALU path and to the FP/fixed-point normalize sequence in the CPU.

Parameters:
- none; data width is fixed at 16 and count width at 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- In  input  16  operand; captured on the accepted start edge.
- Dir  input  1  mode, captured with In: 0 = left normalize (CLZ), 1 = right normalize (CTZ).
- Out  output  16  normalized value.
- Cnt  output  4  shift amount applied.
- Zero  output  1  captured operand was 0.
- busy  output  1  a stage is in progress.
- done  output  1  one-cycle pulse: Out, Cnt and Zero are valid.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; Out=0, Cnt=0, Zero=0, busy=0, done=0. This applies in any state, including mid-operation. Any in-flight result is discarded and no done pulse follows.
- States: IDLE, S8, S4, S2, S1, DONE.
- Start acceptance: start=1 in IDLE or DONE loads the working register with In, Cnt=0, Dir_r=Dir, then goes to S8. start is ignored in S8..S1.
- Stage Sk, for k = 8, 4, 2, 1:
  - Left mode: if the top k bits of the working register are all 0, shift left by k (zero fill) and set the Cnt bit of weight k.
  - Right mode: same test on the bottom k bits, shift right logically by k, set the same Cnt bit.
  - Otherwise the register and Cnt are unchanged.
  - Next state: S8→S4→S2→S1→DONE.
- DONE: done=1 for exactly one cycle, then IDLE unless start=1 (back-to-back accept).
- Latency: start accepted at edge E → busy=1 for the cycles after E, E+1, E+2 and E+3 → done=1 in the cycle after edge E+4.
  - Sustained throughput is one operation per 5 cycles.
- busy=1 exactly in S8..S1; busy=0 in IDLE and DONE.
- Out and Cnt are driven directly from the working registers and change during S8..S1. They are guaranteed valid only while done=1.
  - They hold their final values in IDLE until the next accepted start.
- Zero is computed from the captured operand and set on the S8→S4 step. It holds until the next accept, where it is cleared.
- Nonzero operand:
  - Left mode: Out[15]=1 and Cnt = leading-zero count (0..15).
  - Right mode: Out[0]=1 and Cnt = trailing-zero count (0..15).
  - In both modes, shifting Out back by Cnt in the opposite direction reproduces In exactly.
- Zero operand: Out=0x0000, Cnt=4'hF, Zero=1 in both modes. The natural search result is kept; there is no special-case path.
- Operand already normalized (bit 15 set in left mode, bit 0 set in right mode): Cnt=0, Out=In.
- In and Dir are don't-care except on the accepting edge. Changing them mid-operation has no effect.
- start asserted on the same edge that DONE exits: accepted, DONE→S8. The done pulse still occurs for the previous operation.

Test Plan:
- Reset, then In=0x0001, Dir=0, start → done 5 cycles later; Out=0x8000, Cnt=15, Zero=0; busy high for exactly 4 cycles.
- In=0x00F0: with Dir=0 → Out=0xF000, Cnt=8; rerun with Dir=1 → Out=0x000F, Cnt=4.
- In=0x8000, Dir=0 → Cnt=0, Out=0x8000. In=0x0000, either Dir → Out=0, Cnt=15, Zero=1.
- Pulse start again while busy with In=0x1234; change In/Dir mid-operation → first result unaffected (In=0x0300, Dir=0 → Out=0xC000, Cnt=6); a single done pulse.
- Drop rst_n during S4 of an operation → next cycle all outputs 0, state IDLE, no done; a fresh start afterwards completes normally.
- Back-to-back: start held high through DONE → second operation accepted with no IDLE cycle. Random sweep of 10k operands in both Dir modes; check:
  - Out re-shifted by Cnt in the opposite direction equals In.
  - Out[15] (Dir=0) or Out[0] (Dir=1) is 1 for nonzero In.

Source files
------------

// File: rtl/shift_normalizer.sv
// shift_normalizer: multi-cycle 16-bit normalizer.
// Left mode counts leading zeros and shifts the operand left until bit 15 is 1.
// Right mode counts trailing zeros and shifts it right until bit 0 is 1.
// A binary search resolves one stage per clock: 8, then 4, then 2, then 1.
module shift_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] In,
  input  logic        Dir,
  output logic [15:0] Out,
  output logic [3:0]  Cnt,
  output logic        Zero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S8   = 3'd1,
    S4   = 3'd2,
    S2   = 3'd3,
    S1   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] work_reg, work_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        dir_reg, dir_next;
  logic        zero_reg, zero_next;

  // Stage selection: the width tested this cycle and whether a stage runs at all.
  logic [4:0]  stage_k;
  logic        stage_act;
  logic [15:0] mask_top;
  logic [15:0] mask_bot;
  logic        stage_hit;

  // True when the k bits at the end being removed are all zero.
  // The top mask covers bits [15:16-k]; the bottom mask covers bits [k-1:0].
  always_comb begin
    mask_top  = ~(16'hFFFF >> stage_k);
    mask_bot  = ~(16'hFFFF << stage_k);
    stage_hit = dir_reg ? ((work_reg & mask_bot) == 16'h0000)
                        : ((work_reg & mask_top) == 16'h0000);
  end

  // Next-state, datapath update and status outputs.
  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    zero_next  = zero_reg;
    stage_k    = 5'd0;
    stage_act  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          work_next  = In;
          cnt_next   = 4'd0;
          dir_next   = Dir;
          zero_next  = 1'b0;
          state_next = S8;
        end
      end
      S8: begin
        busy       = 1'b1;
        stage_k    = 5'd8;
        stage_act  = 1'b1;
        // The register still holds the untouched operand during S8.
        zero_next  = (work_reg == 16'h0000);
        state_next = S4;
      end
      S4: begin
        busy       = 1'b1;
        stage_k    = 5'd4;
        stage_act  = 1'b1;
        state_next = S2;
      end
      S2: begin
        busy       = 1'b1;
        stage_k    = 5'd2;
        stage_act  = 1'b1;
        state_next = S1;
      end
      S1: begin
        busy       = 1'b1;
        stage_k    = 5'd1;
        stage_act  = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        // A start here is accepted back-to-back, with no IDLE cycle in between.
        if (start) begin
          work_next  = In;
          cnt_next   = 4'd0;
          dir_next   = Dir;
          zero_next  = 1'b0;
          state_next = S8;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The stage weight k is also the Cnt bit that records the shift.
    if (stage_act && stage_hit) begin
      work_next = dir_reg ? (work_reg >> stage_k) : (work_reg << stage_k);
      cnt_next  = cnt_reg | stage_k[3:0];
    end
  end

  // State and working registers; reset clears everything and drops any in-flight result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      work_reg  <= 16'h0000;
      cnt_reg   <= 4'd0;
      dir_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      zero_reg  <= zero_next;
    end
  end

  assign Out  = work_reg;
  assign Cnt  = cnt_reg;
  assign Zero = zero_reg;

endmodule

// File: tb/tb_shift_normalizer.sv
// tb_shift_normalizer: directed cases with literal expectations, followed by a
// randomized sweep that is checked every cycle against a behavioural model.
module tb_shift_normalizer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] In;
  logic        Dir;
  logic [15:0] Out;
  logic [3:0]  Cnt;
  logic        Zero;
  logic        busy;
  logic        done;

  shift_normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .In    (In),
    .Dir   (Dir),
    .Out   (Out),
    .Cnt   (Cnt),
    .Zero  (Zero),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one shift at a time until the target bit is set.
  task automatic model(input logic [15:0] v_in, input logic d,
                       output logic [15:0] o, output logic [3:0] c, output logic z);
    logic [15:0] v;
    int n;
    v = v_in;
    n = 0;
    if (v == 16'h0000) begin
      o = 16'h0000;
      c = 4'hF;
      z = 1'b1;
    end else begin
      while (d ? !v[0] : !v[15]) begin
        v = d ? (v >> 1) : (v << 1);
        n++;
      end
      o = v;
      c = 4'(n);
      z = 1'b0;
    end
  endtask

  // Model state: edge count, edge of the last accepted start, and its expected result.
  int          cyc      = 0;
  int          last_acc = -100;
  int          accepts  = 0;
  logic [15:0] exp_in;
  logic        exp_dir;
  logic [15:0] exp_out;
  logic [3:0]  exp_cnt;
  logic        exp_zero;
  bit          chk_en   = 0;

  // Monitor: track which rising edges accept a start.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        last_acc = -100;
      end else if (start && (cyc - last_acc >= 5)) begin
        last_acc = cyc;
        exp_in   = In;
        exp_dir  = Dir;
        model(In, Dir, exp_out, exp_cnt, exp_zero);
        accepts++;
      end
    end
  end

  // Compare process: busy/done each cycle, and the full result whenever done is expected.
  initial begin
    int d;
    logic exp_busy, exp_done;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        d        = cyc - last_acc;
        exp_busy = (d >= 0 && d <= 3);
        exp_done = (d == 4);
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        if (exp_done) begin
          chk("out",  32'(Out),  32'(exp_out));
          chk("cnt",  32'(Cnt),  32'(exp_cnt));
          chk("zero", 32'(Zero), 32'(exp_zero));
          if (exp_in != 16'h0000) begin
            if (exp_dir) begin
              chk("reshift_r", 32'(Out << Cnt), 32'(exp_in));
              chk("lsb_set",   32'(Out[0]),     32'd1);
            end else begin
              chk("reshift_l", 32'(Out >> Cnt), 32'(exp_in));
              chk("msb_set",   32'(Out[15]),    32'd1);
            end
          end
        end
      end
    end
  end

  // One operation from IDLE: checks latency, busy length and literal results.
  task automatic run_op(input logic [15:0] v, input logic d,
                        input logic [15:0] eo, input logic [3:0] ec, input logic ez);
    int n;
    int bcnt;
    In    = v;
    Dir   = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n     = 1;
    bcnt  = 0;
    while (!done && n < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      n++;
    end
    chk("latency",    32'(n),    32'd5);
    chk("busy_len",   32'(bcnt), 32'd4);
    chk("lit_out",    32'(Out),  32'(eo));
    chk("lit_cnt",    32'(Cnt),  32'(ec));
    chk("lit_zero",   32'(Zero), 32'(ez));
    @(negedge clk);
  endtask

  initial begin
    int dones;
    logic [15:0] v;
    rst_n = 1'b0;
    start = 1'b0;
    In    = 16'h0000;
    Dir   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out",  32'(Out),  32'd0);
    chk("rst_cnt",  32'(Cnt),  32'd0);
    chk("rst_zero", 32'(Zero), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1;
    @(negedge clk);

    run_op(16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0);
    run_op(16'h00F0, 1'b0, 16'hF000, 4'd8,  1'b0);
    run_op(16'h00F0, 1'b1, 16'h000F, 4'd4,  1'b0);
    run_op(16'h8000, 1'b0, 16'h8000, 4'd0,  1'b0);
    run_op(16'h0000, 1'b0, 16'h0000, 4'd15, 1'b1);
    run_op(16'h0000, 1'b1, 16'h0000, 4'd15, 1'b1);

    // Start pulsed and operands changed while busy: the first result stands.
    In = 16'h0300; Dir = 1'b0; start = 1'b1;
    @(negedge clk);
    In = 16'h1234; Dir = 1'b1;
    @(negedge clk);
    @(negedge clk);
    In = 16'h5555; start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        dones++;
        chk("mid_out", 32'(Out), 32'h0000C000);
        chk("mid_cnt", 32'(Cnt), 32'd6);
      end
      @(negedge clk);
    end
    chk("mid_dones", 32'(dones), 32'd1);

    // Reset during S4: outputs clear next cycle and no done follows.
    In = 16'h0010; Dir = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_out",  32'(Out),  32'd0);
    chk("mrst_cnt",  32'(Cnt),  32'd0);
    chk("mrst_zero", 32'(Zero), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run_op(16'h0010, 1'b0, 16'h8000, 4'd11, 1'b0);

    // Back-to-back: start held high through DONE.
    In = 16'h0001; Dir = 1'b1; start = 1'b1;
    @(negedge clk);
    In = 16'h4000; Dir = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_out1",  32'(Out),  32'h00000001);
    chk("b2b_cnt1",  32'(Cnt),  32'd0);
    @(negedge clk);
    chk("b2b_busy",  32'(busy), 32'd1);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_out2",  32'(Out),  32'h00008000);
    chk("b2b_cnt2",  32'(Cnt),  32'd1);
    repeat (2) @(negedge clk);

    // Random sweep: mostly back-to-back, operands with varied zero runs.
    for (int i = 0; i < 52000; i++) begin
      v     = 16'($urandom);
      v     = v >> $urandom_range(0, 16);
      v     = v << $urandom_range(0, 15);
      In    = v;
      Dir   = 1'($urandom);
      start = ($urandom_range(0, 15) != 0);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("sweep_ran", 32'(accepts > 9000), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
